// File: rtl/uart_bus_port.sv
// uart_bus_port: CPU-bus UART with one THR/shifter transmitter and a receiver feeding byte storage.
// Define UART_RX_FIFO_EN for 4-entry receive FIFO; otherwise a single holding register is used.
module uart_bus_port #(
   parameter int CLK_DIV = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wrn,
   input  logic        rdn,
   input  logic [15:0] data_i,
   output logic [15:0] data_o,
   output logic        data_oe,
   output logic        data_ready,
   output logic        tbre,
   output logic        tsre,
   output logic        txd,
   input  logic        rxd,
   output logic        overrun
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic wrn_q, rdn_q, tbre_q, tbre_d, overrun_q, overrun_d;
   logic [7:0] thr_q, thr_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, head;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d, rx_sync_q;
   logic wr_commit, pop, rx_valid, full, push_ok;
   logic unused_hi;
   assign unused_hi = ^data_i[15:8];
   assign wr_commit = wrn & ~wrn_q;
   assign pop = rdn & ~rdn_q & data_ready;
   assign tbre = tbre_q;
   assign tsre = tx_state_q == IDLE;
   assign txd = tx_state_q == START ? 1'b0 : tx_state_q == DATA ? tx_sh_q[0] : 1'b1;
   assign overrun = overrun_q;
   assign data_oe = rst & ~rdn;
   assign data_o = data_oe ? {8'h00, head} : 16'h0000;
   assign push_ok = rx_valid & (~full | pop);
   assign overrun_d = overrun_q | (rx_valid & full & ~pop);
   // Transmit FSM: THR capture, shifter load and bit timing
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d = tx_cnt_q;
      tx_bit_d = tx_bit_q;
      tx_sh_d = tx_sh_q;
      thr_d = thr_q;
      tbre_d = tbre_q;
      if (wr_commit && tbre_q) begin
         thr_d = data_i[7:0];
         tbre_d = 1'b0;
      end
      case (tx_state_q)
         IDLE: if (!tbre_q) begin
            tx_state_d = START;
            tx_sh_d = thr_q;
            tbre_d = 1'b1;
            tx_cnt_d = '0;
         end
         START: if (tx_cnt_q == BIT_LAST) begin
            tx_state_d = DATA;
            tx_cnt_d = '0;
            tx_bit_d = '0;
         end else tx_cnt_d = tx_cnt_q + 1'b1;
         DATA: if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d = '0;
            tx_sh_d = {1'b1, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 1'b1;
            if (tx_bit_q == 3'd7) tx_state_d = STOP;
         end else tx_cnt_d = tx_cnt_q + 1'b1;
         STOP: if (tx_cnt_q == BIT_LAST) begin
            tx_state_d = IDLE;
            tx_cnt_d = '0;
         end else tx_cnt_d = tx_cnt_q + 1'b1;
      endcase
   end
   // Receive FSM: start detection, mid-bit sampling and stop-bit validation
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d = rx_cnt_q;
      rx_bit_d = rx_bit_q;
      rx_sh_d = rx_sh_q;
      rx_valid = 1'b0;
      case (rx_state_q)
         IDLE: if (!rx_sync_q[1] && rx_sync_q[2]) begin
            rx_state_d = START;
            rx_cnt_d = '0;
         end
         START: if (rx_cnt_q == HALF_LAST) begin
            rx_state_d = rx_sync_q[1] ? IDLE : DATA;
            rx_cnt_d = '0;
            rx_bit_d = '0;
         end else rx_cnt_d = rx_cnt_q + 1'b1;
         DATA: if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d = '0;
            rx_sh_d = {rx_sync_q[1], rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_d = STOP;
         end else rx_cnt_d = rx_cnt_q + 1'b1;
         STOP: if (rx_cnt_q == BIT_LAST) begin
            rx_state_d = IDLE;
            rx_cnt_d = '0;
            rx_valid = rx_sync_q[1];
         end else rx_cnt_d = rx_cnt_q + 1'b1;
      endcase
   end
   // Shared state registers for bus strobes, transmitter and receiver
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrn_q <= 1'b1;
         rdn_q <= 1'b1;
         rx_sync_q <= 3'b111;
         tx_state_q <= IDLE;
         rx_state_q <= IDLE;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         tx_bit_q <= '0;
         rx_bit_q <= '0;
         tx_sh_q <= '0;
         rx_sh_q <= '0;
         thr_q <= '0;
         tbre_q <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         wrn_q <= wrn;
         rdn_q <= rdn;
         rx_sync_q <= {rx_sync_q[1:0], rxd};
         tx_state_q <= tx_state_d;
         rx_state_q <= rx_state_d;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         tx_bit_q <= tx_bit_d;
         rx_bit_q <= rx_bit_d;
         tx_sh_q <= tx_sh_d;
         rx_sh_q <= rx_sh_d;
         thr_q <= thr_d;
         tbre_q <= tbre_d;
         overrun_q <= overrun_d;
      end
   end
`ifdef UART_RX_FIFO_EN
   logic [7:0] mem_q [4];
   logic [7:0] mem_d [4];
   logic [1:0] wp_q, wp_d, rp_q, rp_d;
   logic [2:0] fill_q, fill_d;
   assign full = fill_q == 3'd4;
   assign data_ready = fill_q != 3'd0;
   assign head = mem_q[rp_q];
   // FIFO next state: pop is applied before push so a full FIFO can accept on a read
   always_comb begin
      mem_d = mem_q;
      if (push_ok) mem_d[wp_q] = rx_sh_q;
      wp_d = push_ok ? wp_q + 2'd1 : wp_q;
      rp_d = pop ? rp_q + 2'd1 : rp_q;
      fill_d = fill_q + {2'b00, push_ok} - {2'b00, pop};
   end
   // FIFO storage registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '{default: 8'h00};
         wp_q <= '0;
         rp_q <= '0;
         fill_q <= '0;
      end else begin
         mem_q <= mem_d;
         wp_q <= wp_d;
         rp_q <= rp_d;
         fill_q <= fill_d;
      end
   end
`else
   logic [7:0] hold_q, hold_d;
   logic full_q, full_d;
   assign full = full_q;
   assign data_ready = full_q;
   assign head = hold_q;
   // Holding register next state: a simultaneous read and arrival keeps it full
   always_comb begin
      hold_d = push_ok ? rx_sh_q : hold_q;
      full_d = push_ok | (full_q & ~pop);
   end
   // Holding register storage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
         full_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         full_q <= full_d;
      end
   end
`endif
endmodule

// File: tb/tb_uart_bus_port.sv
// tb_uart_bus_port: directed self-checking bench for uart_bus_port at CLK_DIV=16.
module tb_uart_bus_port;
   logic clk = 1'b0, rst = 1'b0, wrn = 1'b1, rdn = 1'b1, rxd = 1'b1;
   logic [15:0] data_i = 16'h0000;
   logic [15:0] data_o;
   logic data_oe, data_ready, tbre, tsre, txd, overrun;
   int passed = 0, fails = 0, total = 0;

   always #5 clk = ~clk;

   uart_bus_port #(.CLK_DIV(16)) dut (
      .clk(clk), .rst(rst), .wrn(wrn), .rdn(rdn), .data_i(data_i), .data_o(data_o),
      .data_oe(data_oe), .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
      .txd(txd), .rxd(rxd), .overrun(overrun)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic negs(input int n);
      repeat (n) @(negedge clk);
   endtask

   // called at a negedge; returns at the negedge after the commit edge
   task automatic wr(input logic [7:0] b);
      wrn = 1'b0;
      data_i = {8'h00, b};
      negs(1);
      wrn = 1'b1;
      negs(1);
   endtask

   // samples txd mid-bit for start, 8 data bits and stop
   task automatic chk_frame(input logic [7:0] b, input int pre, input string tag);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      negs(pre);
      for (int i = 0; i < 10; i++) begin
         if (i != 0) negs(16);
         chk1($sformatf("%s_bit%0d", tag, i), txd, fr[i]);
      end
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      negs(16);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         negs(16);
      end
      rxd = stop;
      negs(16);
      rxd = 1'b1;
   endtask

   task automatic rd(input logic [7:0] exp, input string tag);
      rdn = 1'b0;
      #1;
      chk1({tag, "_oe"}, data_oe, 1'b1);
      chk16({tag, "_data"}, data_o, {8'h00, exp});
      negs(1);
      rdn = 1'b1;
      negs(1);
   endtask

   initial begin
      rdn = 1'b0;
      negs(3);
      chk1("rst_txd", txd, 1'b1);
      chk1("rst_tbre", tbre, 1'b1);
      chk1("rst_tsre", tsre, 1'b1);
      chk1("rst_dr", data_ready, 1'b0);
      chk1("rst_oe", data_oe, 1'b0);
      chk16("rst_do", data_o, 16'h0000);
      chk1("rst_ovr", overrun, 1'b0);
      rdn = 1'b1;
      negs(1);
      rst = 1'b1;
      negs(2);

      wr(8'h41);
      chk1("w41_tbre_lo", tbre, 1'b0);
      negs(1);
      chk1("w41_tbre_hi", tbre, 1'b1);
      chk1("w41_tsre_lo", tsre, 1'b0);
      chk_frame(8'h41, 8, "f41");
      negs(7);
      chk1("f41_tsre_busy", tsre, 1'b0);
      negs(1);
      chk1("f41_tsre_done", tsre, 1'b1);
      chk1("f41_txd_idle", txd, 1'b1);

      wr(8'h55);
      negs(1);
      chk1("w55_tbre", tbre, 1'b1);
      wr(8'hAA);
      chk1("wAA_tbre", tbre, 1'b0);
      wr(8'hFF);
      chk1("wFF_tbre", tbre, 1'b0);
      chk_frame(8'h55, 4, "f55");
      chk_frame(8'hAA, 17, "fAA");
      negs(8);
      chk1("fAA_tsre", tsre, 1'b1);
      negs(40);
      chk1("drop_txd", txd, 1'b1);
      chk1("drop_tsre", tsre, 1'b1);
      chk1("drop_tbre", tbre, 1'b1);

      rx_frame(8'h3C, 1'b1);
      chk1("r3C_dr", data_ready, 1'b1);
      rd(8'h3C, "r3C");
      chk1("r3C_dr_after", data_ready, 1'b0);
      chk1("r3C_oe_after", data_oe, 1'b0);
      chk16("r3C_do_after", data_o, 16'h0000);

      rx_frame(8'h5A, 1'b0);
      negs(4);
      chk1("bad_stop_dr", data_ready, 1'b0);
      chk1("bad_stop_ovr", overrun, 1'b0);

      rdn = 1'b0;
      #1;
      chk1("empty_rd_oe", data_oe, 1'b1);
      negs(1);
      rdn = 1'b1;
      negs(1);
      chk1("empty_rd_dr", data_ready, 1'b0);

`ifdef UART_RX_FIFO_EN
      rx_frame(8'h11, 1'b1);
      rx_frame(8'h22, 1'b1);
      rx_frame(8'h33, 1'b1);
      rx_frame(8'h44, 1'b1);
      chk1("fifo4_ovr", overrun, 1'b0);
      rx_frame(8'h55, 1'b1);
      negs(2);
      chk1("fifo_ovr", overrun, 1'b1);
      chk1("fifo_dr", data_ready, 1'b1);
      rd(8'h11, "fifo0");
      rd(8'h22, "fifo1");
      rd(8'h33, "fifo2");
      chk1("fifo_dr3", data_ready, 1'b1);
      rd(8'h44, "fifo3");
      chk1("fifo_dr_empty", data_ready, 1'b0);
`else
      rx_frame(8'h11, 1'b1);
      chk1("hold1_ovr", overrun, 1'b0);
      rx_frame(8'h22, 1'b1);
      negs(2);
      chk1("hold_ovr", overrun, 1'b1);
      chk1("hold_dr", data_ready, 1'b1);
      rd(8'h11, "hold");
      chk1("hold_dr_empty", data_ready, 1'b0);
`endif

      wr(8'hF0);
      negs(30);
      rxd = 1'b0;
      negs(40);
      chk1("mid_txd", txd, 1'b0);
      rst = 1'b0;
      rdn = 1'b0;
      #1;
      chk1("mrst_txd", txd, 1'b1);
      chk1("mrst_tbre", tbre, 1'b1);
      chk1("mrst_tsre", tsre, 1'b1);
      chk1("mrst_dr", data_ready, 1'b0);
      chk1("mrst_oe", data_oe, 1'b0);
      chk16("mrst_do", data_o, 16'h0000);
      chk1("mrst_ovr", overrun, 1'b0);
      negs(2);
      rdn = 1'b1;
      rxd = 1'b1;
      negs(1);
      rst = 1'b1;
      negs(200);
      chk1("post_rst_dr", data_ready, 1'b0);
      chk1("post_rst_txd", txd, 1'b1);
      chk1("post_rst_tsre", tsre, 1'b1);
      wr(8'hA5);
      negs(1);
      chk1("wA5_tsre", tsre, 1'b0);
      chk_frame(8'hA5, 8, "fA5");
      negs(8);
      chk1("fA5_tsre", tsre, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/uart_bus_port.md
UART_BUS_PORT -- requirements
Module: uart_bus_port

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 16, giving clk cycles per serial bit (even, minimum 4).
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port wrn, input, 1 bit: CPU write strobe, active low, synchronous to clk.
REQ-005 The block SHALL have port rdn, input, 1 bit: CPU read strobe, active low, synchronous to clk.
REQ-006 The block SHALL have port data_i, input, 16 bits: CPU bus write data; only [7:0] used.
REQ-007 The block SHALL have port data_o, output, 16 bits: CPU bus read data.
REQ-008 The block SHALL have port data_oe, output, 1 bit: high while data_o drives the shared bus.
REQ-009 The block SHALL have ports data_ready, tbre and tsre, outputs, 1 bit each: receive-data-available, transmit-holding-empty and transmit-shifter-empty status.
REQ-010 The block SHALL have port txd, output, 1 bit, and port rxd, input, 1 bit: serial lines, idle high.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky received-byte-lost flag.

Function
REQ-012 Write commit SHALL occur on the first cycle wrn is sampled 1 after being sampled 0; data_i[7:0] is loaded into the THR and tbre is 0 from the next cycle.
REQ-013 A write commit while tbre=0 SHALL be ignored, leaving the THR unchanged.
REQ-014 Transmit states SHALL be IDLE, START, DATA, STOP; IDLE with tbre=0 SHALL move the THR to the shifter next cycle, setting tbre=1 and tsre=0.
REQ-015 The frame SHALL be 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1), each held for exactly CLK_DIV cycles.
REQ-016 tsre SHALL return to 1 the cycle after the stop-bit period ends; a pending THR byte SHALL then start without an extra idle bit.
REQ-017 rxd SHALL pass through a two-flop synchroniser; a 1-to-0 transition in receive IDLE SHALL start reception.
REQ-018 The receiver SHALL re-check the start bit at CLK_DIV/2 (returning to IDLE if it is 1) and sample each data and stop bit CLK_DIV cycles apart.
REQ-019 A stop bit sampled as 0 SHALL discard the byte without touching data_ready or overrun.
REQ-020 A valid byte SHALL be stored and data_ready set the cycle after stop-bit sampling.
REQ-021 While rdn=0, the block SHALL drive data_oe=1 and data_o={8'h00, oldest stored byte}; otherwise data_oe=0 and data_o=0.
REQ-022 Read completion SHALL be the first cycle rdn is sampled 1 after 0; it pops the oldest byte, and data_ready follows storage occupancy.
REQ-023 A read completion with data_ready=0 SHALL have no effect.
REQ-024 A valid byte arriving while storage is full SHALL be discarded and overrun set to 1 until reset.
REQ-025 A pop and a push in the same cycle SHALL both take effect: the pop is applied first, no overrun is flagged, and data_ready stays 1.
REQ-026 Transmitter and receiver SHALL operate fully concurrently.

Reset
REQ-027 While rst=0, the block SHALL set txd=1, tbre=1, tsre=1, data_ready=0, data_oe=0, data_o=0, overrun=0, and both state machines to IDLE.
REQ-028 Reset asserted mid-frame SHALL abort the frame; txd SHALL be 1 immediately and no partial byte SHALL be stored.

Configuration
REQ-029 With macro UART_RX_FIFO_EN defined, receive storage SHALL be a 4-entry FIFO with pointers wrapping modulo 4, and full at 4 entries.
REQ-030 Without UART_RX_FIFO_EN, receive storage SHALL be a single holding register that is full whenever data_ready=1.

Verification
REQ-031 Write 16'h0041 via a 1-cycle wrn pulse, CLK_DIV=16 -> tbre=0 then 1, txd shows 0,1,0,0,0,0,0,1,0,1 at 16 cycles each, then tsre=1.
REQ-032 Two back-to-back writes, 8'h55 then 8'hAA -> frames are contiguous, and a third write while tbre=0 is dropped.
REQ-033 Drive 8'h3C on rxd, then pulse rdn -> data_ready=1, data_o=16'h003C with data_oe=1 during rdn=0, and data_ready=0 after.
REQ-034 Receive a frame with stop bit 0 -> data_ready stays 0 and overrun stays 0.
REQ-035 Without FIFO, receive 2 bytes and read none -> data_o=first byte and overrun=1; with FIFO, 5 bytes -> 4 readable in order and overrun=1.
REQ-036 Pulse rst low mid-transmit and mid-receive -> all outputs take their reset values, and the next write sends a clean frame.
